// File: rtl/jtopl_mod_ctrl_if.sv
// Depth-update handshake between the register file (master) and the modulation scheduler (slave).
interface jtopl_mod_ctrl_if;
  logic       cfg_req;
  logic [1:0] cfg_din;
  logic       cfg_ack;
  logic       cfg_busy;

  modport master (output cfg_req, output cfg_din, input cfg_ack, input cfg_busy);
  modport slave  (input cfg_req, input cfg_din, output cfg_ack, output cfg_busy);
endinterface

// File: rtl/jtopl_mod_ctrl.sv
// OPL modulation scheduler: slot sequencer, LFO pre-divider, AM triangle, vibrato step, frame-aligned depth updates.
// Optional JTOPL_LFO_TEST_EN adds lfo_test_i, which bypasses the pre-divider (one LFO tick per frame).
module jtopl_mod_ctrl #(
  parameter int         SLOTS   = 18,
  parameter logic [6:0] LIM     = 7'd60,
  parameter logic [6:0] AM_TOP  = 7'd104,
  parameter logic [3:0] VIB_DIV = 4'd8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cenop_i,
`ifdef JTOPL_LFO_TEST_EN
  input  logic                   lfo_test_i,
`endif
  jtopl_mod_ctrl_if.slave        cfg,
  output logic [4:0]             slot_o,
  output logic                   zero_o,
  output logic                   lfo_tick_o,
  output logic [4:0]             am_o,
  output logic [2:0]             vib_pos_o,
  output logic                   dam_o,
  output logic                   dvb_o
);
  localparam logic [4:0] SLOT_LAST = 5'(SLOTS - 1);

  typedef enum logic {AM_UP, AM_DOWN}     am_st_t;
  typedef enum logic {CFG_IDLE, CFG_WAIT} cfg_st_t;

  am_st_t     am_st_q, am_st_d;
  cfg_st_t    cfg_st_q, cfg_st_d;
  logic [4:0] slot_q, slot_d;
  logic [6:0] cnt_q, cnt_d;
  logic       tick_q, tick_d;
  logic [6:0] am_cnt_q, am_cnt_d;
  logic [3:0] vdiv_q, vdiv_d;
  logic [2:0] vib_q, vib_d;
  logic [1:0] pend_q, pend_d;
  logic       dam_q, dam_d, dvb_q, dvb_d;
  logic       ack_q, ack_d, busy_q, busy_d;
  logic       block_q, block_d;
  logic       zero, lfo_byp, frame_end;
  logic [6:0] am_inc, am_dec;

`ifdef JTOPL_LFO_TEST_EN
  assign lfo_byp = lfo_test_i;
`else
  assign lfo_byp = 1'b0;
`endif

  assign zero      = (slot_q == 5'd0);
  assign frame_end = cenop_i && (slot_q == SLOT_LAST);
  assign am_inc    = am_cnt_q + 7'd1;
  assign am_dec    = am_cnt_q - 7'd1;

  always_comb begin
    slot_d   = slot_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    am_st_d  = am_st_q;
    am_cnt_d = am_cnt_q;
    vdiv_d   = vdiv_q;
    vib_d    = vib_q;
    cfg_st_d = cfg_st_q;
    pend_d   = pend_q;
    dam_d    = dam_q;
    dvb_d    = dvb_q;
    ack_d    = 1'b0;
    busy_d   = busy_q;
    block_d  = block_q && cfg.cfg_req;

    if (cenop_i)
      slot_d = (slot_q == SLOT_LAST) ? 5'd0 : slot_q + 5'd1;

    if (cenop_i && zero) begin
      if (lfo_byp || cnt_q == LIM) begin
        cnt_d  = 7'd0;
        tick_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + 7'd1;
      end
    end

    if (tick_q) begin
      case (am_st_q)
        AM_UP: begin
          am_cnt_d = am_inc;
          if (am_inc == AM_TOP) am_st_d = AM_DOWN;
        end
        AM_DOWN: begin
          am_cnt_d = am_dec;
          if (am_dec == 7'd0) am_st_d = AM_UP;
        end
        default: am_st_d = AM_UP;
      endcase
      if (vdiv_q == VIB_DIV - 4'd1) begin
        vdiv_d = 4'd0;
        vib_d  = vib_q + 3'd1;
      end else begin
        vdiv_d = vdiv_q + 4'd1;
      end
    end

    // block_q keeps a request still held after its ack from being taken a second time
    case (cfg_st_q)
      CFG_IDLE: begin
        if (cfg.cfg_req && !ack_q && !block_q) begin
          pend_d   = cfg.cfg_din;
          busy_d   = 1'b1;
          cfg_st_d = CFG_WAIT;
        end
      end
      CFG_WAIT: begin
        if (frame_end) begin
          {dam_d, dvb_d} = pend_q;
          ack_d    = 1'b1;
          busy_d   = 1'b0;
          block_d  = 1'b1;
          cfg_st_d = CFG_IDLE;
        end
      end
      default: cfg_st_d = CFG_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q   <= 5'd0;
      cnt_q    <= 7'd0;
      tick_q   <= 1'b0;
      am_st_q  <= AM_UP;
      am_cnt_q <= 7'd0;
      vdiv_q   <= 4'd0;
      vib_q    <= 3'd0;
      cfg_st_q <= CFG_IDLE;
      pend_q   <= 2'd0;
      dam_q    <= 1'b0;
      dvb_q    <= 1'b0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      block_q  <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      am_st_q  <= am_st_d;
      am_cnt_q <= am_cnt_d;
      vdiv_q   <= vdiv_d;
      vib_q    <= vib_d;
      cfg_st_q <= cfg_st_d;
      pend_q   <= pend_d;
      dam_q    <= dam_d;
      dvb_q    <= dvb_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      block_q  <= block_d;
    end
  end

  assign slot_o       = slot_q;
  assign zero_o       = zero;
  assign lfo_tick_o   = tick_q;
  assign am_o         = dam_q ? am_cnt_q[6:2] : {2'b00, am_cnt_q[6:4]};
  assign vib_pos_o    = vib_q;
  assign dam_o        = dam_q;
  assign dvb_o        = dvb_q;
  assign cfg.cfg_ack  = ack_q;
  assign cfg.cfg_busy = busy_q;
endmodule
